// File: rtl/video_timing_gen.sv
// Raster timing generator with frame-buffer fetch control and line doubling.
// Ports: clk/rstn/en/line_dbl in; Mem_* fetch side; Out_p* encoder side; Frame_Start pulse.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RD_LAT   = 1,
    parameter int ADDR_W   = 20
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              line_dbl,
    output logic              Mem_Read,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic [23:0]       Mem_Data,
    output logic [23:0]       Out_pData,
    output logic              Out_pHSync,
    output logic              Out_pVSync,
    output logic              Out_pVDE,
    output logic              Frame_Start
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] HS_W   = 12'(H_SYNC);
    localparam logic [11:0] VS_W   = 12'(V_SYNC);
    localparam logic [11:0] HA0    = 12'(H_SYNC + H_BP);
    localparam logic [11:0] HA1    = 12'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [11:0] VA0    = 12'(V_SYNC + V_BP);
    localparam logic [11:0] VA1    = 12'(V_SYNC + V_BP + V_ACTIVE - 1);
    // Fetch window leads the display window by the memory latency.
    localparam logic [11:0] RA0    = 12'(H_SYNC + H_BP - RD_LAT);
    localparam logic [11:0] RA1    = 12'(H_SYNC + H_BP + H_ACTIVE - 1 - RD_LAT);

    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    logic [11:0]       h_cnt_q, h_cnt_d;
    logic [11:0]       v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dbl_q, dbl_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              de_q, de_d;
    logic              rd_q, rd_d;
    logic              fs_q, fs_d;

    logic h_wrap;
    logic v_wrap;
    logic top;
    logic v_act;
    logic h_act;
    logic r_win;
    logic line_odd;

    assign h_wrap = (h_cnt_q == H_LAST);
    assign v_wrap = (v_cnt_q == V_LAST);
    assign top    = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    assign v_act  = (v_cnt_q >= VA0) && (v_cnt_q <= VA1);
    assign h_act  = (h_cnt_q >= HA0) && (h_cnt_q <= HA1);
    assign r_win  = (h_cnt_q >= RA0) && (h_cnt_q <= RA1);
    // Parity of the active-line index (v_cnt - VA0).
    assign line_odd = v_cnt_q[0] ^ VA0[0];

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        base_d  = base_q;
        addr_d  = addr_q;
        dbl_d   = dbl_q;
        hs_d    = ~HS_POL;
        vs_d    = ~VS_POL;
        de_d    = 1'b0;
        rd_d    = 1'b0;
        fs_d    = 1'b0;

        if (!en) begin
            h_cnt_d = 12'd0;
            v_cnt_d = 12'd0;
            base_d  = '0;
            addr_d  = '0;
        end else begin
            h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? 12'd0 : v_cnt_q + 12'd1;
            end

            hs_d = (h_cnt_q < HS_W) ? HS_POL : ~HS_POL;
            vs_d = (v_cnt_q < VS_W) ? VS_POL : ~VS_POL;
            de_d = h_act && v_act;
            rd_d = r_win && v_act;
            fs_d = top;

            // First fetch of a line loads the line base, later ones step.
            if (r_win && v_act) begin
                addr_d = (h_cnt_q == RA0) ? base_q : addr_q + ADDR_ONE;
            end

            if (top) begin
                base_d = '0;
                dbl_d  = line_dbl;
            end else if (v_act && (h_cnt_q == HA1)) begin
                // In doubling mode each source line is shown twice.
                if (!dbl_q || line_odd) begin
                    base_d = base_q + LINE_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
            base_q  <= '0;
            addr_q  <= '0;
            dbl_q   <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            rd_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            dbl_q   <= dbl_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            rd_q    <= rd_d;
            fs_q    <= fs_d;
        end
    end

    assign Mem_Read    = rd_q;
    assign Mem_Addr    = addr_q;
    assign Out_pHSync  = hs_q;
    assign Out_pVSync  = vs_q;
    assign Out_pVDE    = de_q;
    assign Frame_Start = fs_q;
    assign Out_pData   = de_q ? Mem_Data : 24'h000000;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a small 15x7 raster.
// Fetch addresses and pixels are queued per frame and popped by a monitor.
module tb_video_timing_gen;

    localparam int RL = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        line_dbl = 1'b0;
    logic        Mem_Read;
    logic [11:0] Mem_Addr;
    logic [23:0] Mem_Data;
    logic [23:0] Out_pData;
    logic        Out_pHSync;
    logic        Out_pVSync;
    logic        Out_pVDE;
    logic        Frame_Start;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_hs = 0, n_vs = 0, n_de = 0, n_rd = 0;
    int rd_rise = 0;
    bit rd_prev = 0, de_prev = 0;
    int aq[$];
    int dq[$];
    logic [12:0] pipe [0:RL-1] = '{default: '0};

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .RD_LAT(RL), .ADDR_W(12)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .line_dbl(line_dbl),
        .Mem_Read(Mem_Read), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data),
        .Out_pData(Out_pData), .Out_pHSync(Out_pHSync),
        .Out_pVSync(Out_pVSync), .Out_pVDE(Out_pVDE),
        .Frame_Start(Frame_Start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        pipe[0] <= {Mem_Read, Mem_Addr};
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end

    // Frame buffer model: returns tagged address RL cycles after a read.
    always_comb begin
        Mem_Data = 24'hFFFFFF;
        if (pipe[RL-1][12]) Mem_Data = {12'h0C3, pipe[RL-1][11:0]};
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input bit dbl);
        for (int l = 0; l < 4; l++)
            for (int p = 0; p < 8; p++) begin
                int a;
                a = (dbl ? (l >> 1) : l) * 8 + p;
                aq.push_back(a);
                dq.push_back(32'h0C3000 | a);
            end
    endtask

    task automatic wait_fs(output int at);
        bit hit;
        hit = 0;
        at = -1;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk); #1;
            if (Frame_Start) begin
                hit = 1;
                at = cyc;
            end
        end
        if (!hit) chk("fs_timeout", 0, 1);
    endtask

    task automatic start_run(input bit dbl);
        @(posedge clk); #1;
        en = 1'b1;
        push_frame(dbl);
        @(negedge clk); #1;
        chk("fs_first_cycle", Frame_Start, 0);
        @(negedge clk); #1;
        chk("fs_pulse", Frame_Start, 1);
        chk("hs_at_start", Out_pHSync, 0);
        chk("vs_at_start", Out_pVSync, 1);
    endtask

    // Monitor: pops expectations whenever the DUT fetches or displays.
    always @(negedge clk) begin
        if (rstn) begin
            if (Mem_Read) begin
                n_rd++;
                if (!rd_prev) rd_rise = cyc;
                if (aq.size() == 0) chk("addr_q_empty", 1, 0);
                else chk("mem_addr", int'(Mem_Addr), aq.pop_front());
            end
            if (Out_pVDE) begin
                n_de++;
                if (!de_prev) chk("rd_lead", cyc - rd_rise, RL);
                if (dq.size() == 0) chk("data_q_empty", 1, 0);
                else chk("pix", int'(Out_pData), dq.pop_front());
            end else begin
                chk("blank", int'(Out_pData), 0);
            end
            if (Out_pHSync == 1'b0) n_hs++;
            if (Out_pVSync == 1'b1) n_vs++;
            rd_prev = Mem_Read;
            de_prev = Out_pVDE;
        end
    end

    initial begin
        int fs0, fs1, fs2, fs3;
        int s_hs, s_vs, s_de, s_rd;
        bit hit;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd", Mem_Read, 0);
        chk("rst_addr", int'(Mem_Addr), 0);
        chk("rst_de", Out_pVDE, 0);
        chk("rst_fs", Frame_Start, 0);
        chk("rst_hs", Out_pHSync, 1);
        chk("rst_vs", Out_pVSync, 0);
        chk("rst_data", int'(Out_pData), 0);

        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_de", Out_pVDE, 0);
        chk("idle_fs", Frame_Start, 0);

        start_run(1'b0);
        fs0 = cyc;
        s_hs = n_hs; s_vs = n_vs; s_de = n_de; s_rd = n_rd;

        repeat (40) @(negedge clk);
        line_dbl = 1'b1;
        wait_fs(fs1);
        chk("frame_period", fs1 - fs0, 105);
        chk("hs_per_frame", n_hs - s_hs, 21);
        chk("vs_per_frame", n_vs - s_vs, 15);
        chk("de_per_frame", n_de - s_de, 32);
        chk("rd_per_frame", n_rd - s_rd, 32);
        chk("q_drained_f0", aq.size() + dq.size(), 0);
        push_frame(1'b1);

        repeat (40) @(negedge clk);
        line_dbl = 1'b0;
        wait_fs(fs2);
        chk("frame_period_dbl", fs2 - fs1, 105);
        chk("q_drained_f1", aq.size() + dq.size(), 0);
        push_frame(1'b0);

        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk); #1;
            if (Mem_Read && Mem_Addr == 12'd10) hit = 1;
        end
        chk("addr10_seen", hit, 1);

        @(posedge clk); #1;
        en = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("drop_rd", Mem_Read, 0);
        chk("drop_de", Out_pVDE, 0);
        chk("drop_addr", int'(Mem_Addr), 0);
        chk("drop_hs", Out_pHSync, 1);
        chk("drop_vs", Out_pVSync, 0);
        chk("drop_fs", Frame_Start, 0);
        chk("drop_data", int'(Out_pData), 0);
        aq.delete();
        dq.delete();
        repeat (8) @(posedge clk);
        #1;
        chk("hold_rd", Mem_Read, 0);
        chk("hold_de", Out_pVDE, 0);

        start_run(1'b0);
        fs2 = cyc;
        wait_fs(fs3);
        chk("frame_period_resume", fs3 - fs2, 105);
        chk("q_drained_resume", aq.size() + dq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
